// File: rtl/id_stage_pipe_pkg.sv
// Shared definitions for the ID stage: opcodes, function codes, ALU codes and reset level.
package id_stage_pipe_pkg;

    // Reset is asserted when rst equals this level.
    localparam logic RstEnable = 1'b0;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    localparam int unsigned AluOpW  = 8;
    localparam int unsigned AluSelW = 3;

    // Primary opcodes
    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpAndi    = 6'b001100;
    localparam logic [5:0] OpOri     = 6'b001101;
    localparam logic [5:0] OpXori    = 6'b001110;
    localparam logic [5:0] OpLui     = 6'b001111;
    localparam logic [5:0] OpSlti    = 6'b001010;
    localparam logic [5:0] OpSltiu   = 6'b001011;
    localparam logic [5:0] OpAddiu   = 6'b001001;
    localparam logic [5:0] OpLw      = 6'b100011;

    // SPECIAL function codes
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnNor  = 6'b100111;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnSltu = 6'b101011;
    localparam logic [5:0] FnAddu = 6'b100001;
    localparam logic [5:0] FnSubu = 6'b100011;
    localparam logic [5:0] FnSllv = 6'b000100;
    localparam logic [5:0] FnSrlv = 6'b000110;
    localparam logic [5:0] FnSrav = 6'b000111;
    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnSra  = 6'b000011;

    // ALU operations
    localparam logic [AluOpW-1:0] AluOpNop  = 8'b0000_0000;
    localparam logic [AluOpW-1:0] AluOpAnd  = 8'b0010_0100;
    localparam logic [AluOpW-1:0] AluOpOr   = 8'b0010_0101;
    localparam logic [AluOpW-1:0] AluOpXor  = 8'b0010_0110;
    localparam logic [AluOpW-1:0] AluOpNor  = 8'b0010_0111;
    localparam logic [AluOpW-1:0] AluOpSlt  = 8'b0010_1010;
    localparam logic [AluOpW-1:0] AluOpSltu = 8'b0010_1011;
    localparam logic [AluOpW-1:0] AluOpAdd  = 8'b0010_0001;
    localparam logic [AluOpW-1:0] AluOpSub  = 8'b0010_0011;
    localparam logic [AluOpW-1:0] AluOpSll  = 8'b0111_1100;
    localparam logic [AluOpW-1:0] AluOpSrl  = 8'b0000_0010;
    localparam logic [AluOpW-1:0] AluOpSra  = 8'b0000_0011;
    localparam logic [AluOpW-1:0] AluOpLw   = 8'b1110_0011;

    // Result-class selects
    localparam logic [AluSelW-1:0] AluSelResNop       = 3'b000;
    localparam logic [AluSelW-1:0] AluSelResLogic     = 3'b001;
    localparam logic [AluSelW-1:0] AluSelResShift     = 3'b010;
    localparam logic [AluSelW-1:0] AluSelResArith     = 3'b100;
    localparam logic [AluSelW-1:0] AluSelResLoadStore = 3'b111;

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand selector: $0, EX forward, MEM forward, regfile data or immediate.
module id_fwd_mux
    import id_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          FWD_EN     = 1'b1
) (
    input  logic                  read_en,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     rf_data,
    input  logic [DATA_W-1:0]     imm,
    input  logic                  ex_wreg,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  mem_wreg,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     operand
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = FWD_EN && ex_wreg && (ex_wd == addr);
    assign mem_hit = FWD_EN && mem_wreg && (mem_wd == addr);

    // Youngest producer wins: EX before MEM before the register file.
    always_comb begin
        operand = rf_data;
        if (!read_en) begin
            operand = imm;
        end else if (addr == REG_ADDR_W'(NOPRegAddr)) begin
            operand = '0;
        end else if (ex_hit) begin
            operand = ex_wdata;
        end else if (mem_hit) begin
            operand = mem_wdata;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with operand forwarding, load-use stall and an ID/EX register.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid_i,
    input  logic [31:0]           if_pc_i,
    input  logic [31:0]           if_inst_i,
    output logic                  id_ready_o,
    output logic                  reg1_read_o,
    output logic                  reg2_read_o,
    output logic [REG_ADDR_W-1:0] reg1_addr_o,
    output logic [REG_ADDR_W-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0]     reg1_data_i,
    input  logic [DATA_W-1:0]     reg2_data_i,
    input  logic                  ex_wreg_i,
    input  logic                  mem_wreg_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic [REG_ADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0]     ex_wdata_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_ready_i,
    input  logic                  flush_i,
    output logic                  id_valid_o,
    output logic [AluOpW-1:0]     aluop_o,
    output logic [AluSelW-1:0]    alusel_o,
    output logic [DATA_W-1:0]     reg1_o,
    output logic [DATA_W-1:0]     reg2_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic                  is_load_o,
    output logic [31:0]           pc_o,
    output logic                  inst_invalid_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    // Instruction fields
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign op    = if_inst_i[31:26];
    assign rs    = if_inst_i[25:21];
    assign rt    = if_inst_i[20:16];
    assign rd    = if_inst_i[15:11];
    assign shamt = if_inst_i[10:6];
    assign funct = if_inst_i[5:0];
    assign imm16 = if_inst_i[15:0];

    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_lui;
    logic [DATA_W-1:0] shamt_zext;

    assign imm_zext   = DATA_W'(imm16);
    assign imm_sext   = {{(DATA_W-16){imm16[15]}}, imm16};
    assign imm_lui    = DATA_W'({imm16, 16'h0000});
    assign shamt_zext = DATA_W'(shamt);

    // Decoded control
    logic [AluOpW-1:0]     dec_aluop;
    logic [AluSelW-1:0]    dec_alusel;
    logic                  rd1_en;
    logic                  rd2_en;
    logic [REG_ADDR_W-1:0] rd1_addr;
    logic [REG_ADDR_W-1:0] rd2_addr;
    logic [REG_ADDR_W-1:0] dec_wd;
    logic                  dec_wreg_raw;
    logic                  dec_wreg;
    logic                  dec_load;
    logic                  dec_invalid;
    logic [DATA_W-1:0]     imm1;
    logic [DATA_W-1:0]     imm2;

    // Combinational decode of the instruction word.
    always_comb begin
        dec_aluop    = AluOpNop;
        dec_alusel   = AluSelResNop;
        rd1_en       = 1'b0;
        rd2_en       = 1'b0;
        rd1_addr     = REG_ADDR_W'(rs);
        rd2_addr     = REG_ADDR_W'(rt);
        dec_wd       = REG_ADDR_W'(NOPRegAddr);
        dec_wreg_raw = 1'b0;
        dec_load     = 1'b0;
        dec_invalid  = 1'b0;
        imm1         = '0;
        imm2         = '0;

        unique case (op)
            OpSpecial: begin
                rd1_en       = 1'b1;
                rd2_en       = 1'b1;
                dec_wd       = REG_ADDR_W'(rd);
                dec_wreg_raw = 1'b1;
                unique case (funct)
                    FnAnd:  begin dec_aluop = AluOpAnd;  dec_alusel = AluSelResLogic; end
                    FnOr:   begin dec_aluop = AluOpOr;   dec_alusel = AluSelResLogic; end
                    FnXor:  begin dec_aluop = AluOpXor;  dec_alusel = AluSelResLogic; end
                    FnNor:  begin dec_aluop = AluOpNor;  dec_alusel = AluSelResLogic; end
                    FnSlt:  begin dec_aluop = AluOpSlt;  dec_alusel = AluSelResArith; end
                    FnSltu: begin dec_aluop = AluOpSltu; dec_alusel = AluSelResArith; end
                    FnAddu: begin dec_aluop = AluOpAdd;  dec_alusel = AluSelResArith; end
                    FnSubu: begin dec_aluop = AluOpSub;  dec_alusel = AluSelResArith; end
                    FnSllv: begin dec_aluop = AluOpSll;  dec_alusel = AluSelResShift; end
                    FnSrlv: begin dec_aluop = AluOpSrl;  dec_alusel = AluSelResShift; end
                    FnSrav: begin dec_aluop = AluOpSra;  dec_alusel = AluSelResShift; end
                    // Constant shifts take the amount from shamt on port 1.
                    FnSll, FnSrl, FnSra: begin
                        rd1_en     = 1'b0;
                        imm1       = shamt_zext;
                        dec_alusel = AluSelResShift;
                        dec_aluop  = (funct == FnSll) ? AluOpSll :
                                     (funct == FnSrl) ? AluOpSrl : AluOpSra;
                    end
                    default: begin
                        rd1_en       = 1'b0;
                        rd2_en       = 1'b0;
                        dec_wreg_raw = 1'b0;
                        dec_invalid  = 1'b1;
                    end
                endcase
            end
            OpAndi, OpOri, OpXori, OpLui, OpSlti, OpSltiu, OpAddiu, OpLw: begin
                rd1_en       = 1'b1;
                dec_wd       = REG_ADDR_W'(rt);
                dec_wreg_raw = 1'b1;
                imm2         = imm_sext;
                unique case (op)
                    OpAndi: begin
                        dec_aluop = AluOpAnd; dec_alusel = AluSelResLogic; imm2 = imm_zext;
                    end
                    OpOri: begin
                        dec_aluop = AluOpOr;  dec_alusel = AluSelResLogic; imm2 = imm_zext;
                    end
                    OpXori: begin
                        dec_aluop = AluOpXor; dec_alusel = AluSelResLogic; imm2 = imm_zext;
                    end
                    // LUI is OR with $0 and the shifted immediate.
                    OpLui: begin
                        dec_aluop  = AluOpOr;
                        dec_alusel = AluSelResLogic;
                        rd1_addr   = REG_ADDR_W'(NOPRegAddr);
                        imm2       = imm_lui;
                    end
                    OpSlti:  begin dec_aluop = AluOpSlt;  dec_alusel = AluSelResArith; end
                    OpSltiu: begin dec_aluop = AluOpSltu; dec_alusel = AluSelResArith; end
                    OpAddiu: begin dec_aluop = AluOpAdd;  dec_alusel = AluSelResArith; end
                    default: begin
                        dec_aluop  = AluOpLw;
                        dec_alusel = AluSelResLoadStore;
                        dec_load   = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_invalid = 1'b1;
            end
        endcase
    end

    assign dec_wreg = dec_wreg_raw && (dec_wd != REG_ADDR_W'(NOPRegAddr));

    assign reg1_read_o = rd1_en;
    assign reg2_read_o = rd2_en;
    assign reg1_addr_o = rd1_addr;
    assign reg2_addr_o = rd2_addr;

    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;

    id_fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_fwd1 (
        .read_en   (rd1_en),
        .addr      (rd1_addr),
        .rf_data   (reg1_data_i),
        .imm       (imm1),
        .ex_wreg   (ex_wreg_i),
        .ex_wd     (ex_wd_i),
        .ex_wdata  (ex_wdata_i),
        .mem_wreg  (mem_wreg_i),
        .mem_wd    (mem_wd_i),
        .mem_wdata (mem_wdata_i),
        .operand   (opnd1)
    );

    id_fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_fwd2 (
        .read_en   (rd2_en),
        .addr      (rd2_addr),
        .rf_data   (reg2_data_i),
        .imm       (imm2),
        .ex_wreg   (ex_wreg_i),
        .ex_wd     (ex_wd_i),
        .ex_wdata  (ex_wdata_i),
        .mem_wreg  (mem_wreg_i),
        .mem_wd    (mem_wd_i),
        .mem_wdata (mem_wdata_i),
        .operand   (opnd2)
    );

    // ID/EX register state
    logic                  valid_q,   valid_d;
    logic [AluOpW-1:0]     aluop_q,   aluop_d;
    logic [AluSelW-1:0]    alusel_q,  alusel_d;
    logic [DATA_W-1:0]     reg1_q,    reg1_d;
    logic [DATA_W-1:0]     reg2_q,    reg2_d;
    logic [REG_ADDR_W-1:0] wd_q,      wd_d;
    logic                  wreg_q,    wreg_d;
    logic                  load_q,    load_d;
    logic [31:0]           pc_q,      pc_d;
    logic                  invalid_q, invalid_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    logic load_use;
    logic advance;

    // A loaded value still in EX cannot be forwarded; the consumer must wait a cycle.
    assign load_use = if_valid_i && ex_is_load_i && ex_wreg_i &&
                      (ex_wd_i != REG_ADDR_W'(NOPRegAddr)) &&
                      ((rd1_en && (rd1_addr == ex_wd_i)) || (rd2_en && (rd2_addr == ex_wd_i)));

    assign advance    = ex_ready_i || !valid_q;
    assign id_ready_o = flush_i || (advance && !load_use);

    // Next-state for the ID/EX register and the stall counter.
    always_comb begin
        valid_d   = valid_q;
        aluop_d   = aluop_q;
        alusel_d  = alusel_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        wd_d      = wd_q;
        wreg_d    = wreg_q;
        load_d    = load_q;
        pc_d      = pc_q;
        invalid_d = invalid_q;
        cnt_d     = cnt_q;

        if (flush_i) begin
            valid_d = 1'b0;
            wreg_d  = 1'b0;
        end else if (advance) begin
            if (load_use) begin
                valid_d   = 1'b0;
                aluop_d   = AluOpNop;
                alusel_d  = AluSelResNop;
                reg1_d    = '0;
                reg2_d    = '0;
                wd_d      = REG_ADDR_W'(NOPRegAddr);
                wreg_d    = 1'b0;
                load_d    = 1'b0;
                pc_d      = ZeroWord;
                invalid_d = 1'b0;
            end else begin
                valid_d   = if_valid_i;
                aluop_d   = dec_aluop;
                alusel_d  = dec_alusel;
                reg1_d    = opnd1;
                reg2_d    = opnd2;
                wd_d      = dec_wd;
                wreg_d    = dec_wreg;
                load_d    = dec_load;
                pc_d      = if_pc_i;
                invalid_d = dec_invalid;
            end
        end

        if (load_use && !flush_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ID/EX register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q   <= 1'b0;
            aluop_q   <= AluOpNop;
            alusel_q  <= AluSelResNop;
            reg1_q    <= '0;
            reg2_q    <= '0;
            wd_q      <= REG_ADDR_W'(NOPRegAddr);
            wreg_q    <= 1'b0;
            load_q    <= 1'b0;
            pc_q      <= ZeroWord;
            invalid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            alusel_q  <= alusel_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
            load_q    <= load_d;
            pc_q      <= pc_d;
            invalid_q <= invalid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign id_valid_o     = valid_q;
    assign aluop_o        = aluop_q;
    assign alusel_o       = alusel_q;
    assign reg1_o         = reg1_q;
    assign reg2_o         = reg2_q;
    assign wd_o           = wd_q;
    assign wreg_o         = wreg_q;
    assign is_load_o      = load_q;
    assign pc_o           = pc_q;
    assign inst_invalid_o = invalid_q;
    assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (forwarding and non-forwarding instances).
module tb_id_stage_pipe;

    // Hand-written encodings
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_ADD = 8'h21;
    localparam logic [7:0] OP_SLL = 8'h7C;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd4;
    localparam logic [2:0] SEL_LS    = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;
    logic [31:0] reg1_data, reg2_data;
    logic        ex_wreg, mem_wreg, ex_is_load, ex_ready, flush;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;

    logic        id_ready, r1_rd, r2_rd, id_valid, wreg, is_load, invalid;
    logic [4:0]  r1_a, r2_a, wd;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2, pc;
    logic [3:0]  stall_cnt;

    logic        nf_id_ready, nf_r1_rd, nf_r2_rd, nf_id_valid, nf_wreg, nf_is_load, nf_invalid;
    logic [4:0]  nf_r1_a, nf_r2_a, nf_wd;
    logic [7:0]  nf_aluop;
    logic [2:0]  nf_alusel;
    logic [31:0] nf_reg1, nf_reg2, nf_pc;
    logic [3:0]  nf_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_pc_i(if_pc), .if_inst_i(if_inst),
        .id_ready_o(id_ready), .reg1_read_o(r1_rd), .reg2_read_o(r2_rd),
        .reg1_addr_o(r1_a), .reg2_addr_o(r2_a), .reg1_data_i(reg1_data),
        .reg2_data_i(reg2_data), .ex_wreg_i(ex_wreg), .mem_wreg_i(mem_wreg),
        .ex_wd_i(ex_wd), .mem_wd_i(mem_wd), .ex_wdata_i(ex_wdata), .mem_wdata_i(mem_wdata),
        .ex_is_load_i(ex_is_load), .ex_ready_i(ex_ready), .flush_i(flush),
        .id_valid_o(id_valid), .aluop_o(aluop), .alusel_o(alusel), .reg1_o(reg1),
        .reg2_o(reg2), .wd_o(wd), .wreg_o(wreg), .is_load_o(is_load), .pc_o(pc),
        .inst_invalid_o(invalid), .stall_cnt_o(stall_cnt)
    );

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(4)) dut_nf (
        .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_pc_i(if_pc), .if_inst_i(if_inst),
        .id_ready_o(nf_id_ready), .reg1_read_o(nf_r1_rd), .reg2_read_o(nf_r2_rd),
        .reg1_addr_o(nf_r1_a), .reg2_addr_o(nf_r2_a), .reg1_data_i(reg1_data),
        .reg2_data_i(reg2_data), .ex_wreg_i(ex_wreg), .mem_wreg_i(mem_wreg),
        .ex_wd_i(ex_wd), .mem_wd_i(mem_wd), .ex_wdata_i(ex_wdata), .mem_wdata_i(mem_wdata),
        .ex_is_load_i(ex_is_load), .ex_ready_i(ex_ready), .flush_i(flush),
        .id_valid_o(nf_id_valid), .aluop_o(nf_aluop), .alusel_o(nf_alusel),
        .reg1_o(nf_reg1), .reg2_o(nf_reg2), .wd_o(nf_wd), .wreg_o(nf_wreg),
        .is_load_o(nf_is_load), .pc_o(nf_pc), .inst_invalid_o(nf_invalid),
        .stall_cnt_o(nf_stall_cnt)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_wreg = 1'b0; ex_wd = 5'd0; ex_wdata = 32'h0; ex_is_load = 1'b0;
        mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_valid = 1'b0; if_pc = 32'h0; if_inst = 32'h0;
        reg1_data = 32'h0; reg2_data = 32'h0; ex_ready = 1'b1; flush = 1'b0;
        clear_fwd();
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %h want 0", id_valid); end
        checks++; if (aluop !== OP_NOP) begin errors++; $display("FAIL rst_aluop: got %h want %h", aluop, OP_NOP); end
        checks++; if (alusel !== SEL_NOP) begin errors++; $display("FAIL rst_alusel: got %h want %h", alusel, SEL_NOP); end
        checks++; if ({reg1, reg2, pc} !== 96'h0) begin errors++; $display("FAIL rst_data: got %h %h %h want 0", reg1, reg2, pc); end
        checks++; if ({wd, wreg, is_load, invalid} !== 8'h0) begin errors++; $display("FAIL rst_ctrl: got %h %h %h %h want 0", wd, wreg, is_load, invalid); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %h want 1", id_ready); end
    endtask

    task automatic test_ori();
        if_valid = 1'b1; if_pc = 32'h0000_0100; if_inst = 32'h3401_1234;
        reg1_data = 32'hDEAD_BEEF; reg2_data = 32'hCAFE_F00D;
        #1;
        checks++; if ({r1_rd, r1_a, r2_rd} !== {1'b1, 5'd0, 1'b0}) begin errors++; $display("FAIL ori_reads: got %h %h %h want 1 0 0", r1_rd, r1_a, r2_rd); end
        tick();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ori_valid: got %h want 1", id_valid); end
        checks++; if (aluop !== OP_OR) begin errors++; $display("FAIL ori_aluop: got %h want %h", aluop, OP_OR); end
        checks++; if (reg1 !== 32'h0) begin errors++; $display("FAIL ori_reg1: got %h want 0", reg1); end
        checks++; if (reg2 !== 32'h0000_1234) begin errors++; $display("FAIL ori_reg2: got %h want 00001234", reg2); end
        checks++; if ({wd, wreg} !== {5'd1, 1'b1}) begin errors++; $display("FAIL ori_wd: got %h %h want 1 1", wd, wreg); end
        checks++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL ori_pc: got %h want 00000100", pc); end
    endtask

    task automatic test_forward();
        reg1_data = 32'h1111_1111; if_inst = 32'h0020_2025; if_pc = 32'h104;
        ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'hAAAA_0000;
        mem_wreg = 1'b1; mem_wd = 5'd1; mem_wdata = 32'h0000_5555;
        tick();
        checks++; if (reg1 !== 32'hAAAA_0000) begin errors++; $display("FAIL fwd_ex: got %h want AAAA0000", reg1); end
        checks++; if (nf_reg1 !== 32'h1111_1111) begin errors++; $display("FAIL fwd_off: got %h want 11111111", nf_reg1); end
        checks++; if ({reg2, wd} !== {32'h0, 5'd4}) begin errors++; $display("FAIL fwd_rt0: got %h %h want 0 4", reg2, wd); end
        ex_wreg = 1'b0;
        tick();
        checks++; if (reg1 !== 32'h0000_5555) begin errors++; $display("FAIL fwd_mem: got %h want 00005555", reg1); end
        checks++; if (nf_reg1 !== 32'h1111_1111) begin errors++; $display("FAIL fwd_off_mem: got %h want 11111111", nf_reg1); end
    endtask

    task automatic test_load_use();
        clear_fwd();
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd2; ex_wdata = 32'hBAD0_BAD0;
        if_inst = 32'h0042_1821; if_pc = 32'h108;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_ready: got %h want 0", id_ready); end
        tick();
        checks++; if ({id_valid, wreg} !== 2'b00) begin errors++; $display("FAIL lu_bubble: got %h %h want 0 0", id_valid, wreg); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
        ex_is_load = 1'b0; ex_wdata = 32'h0000_0007;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %h want 1", id_ready); end
        tick();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL addu_valid: got %h want 1", id_valid); end
        checks++; if ({reg1, reg2} !== {32'h7, 32'h7}) begin errors++; $display("FAIL addu_ops: got %h %h want 7 7", reg1, reg2); end
        checks++; if ({aluop, alusel} !== {OP_ADD, SEL_ARITH}) begin errors++; $display("FAIL addu_op: got %h %h want %h %h", aluop, alusel, OP_ADD, SEL_ARITH); end
        checks++; if ({wd, wreg, stall_cnt} !== {5'd3, 1'b1, 4'd1}) begin errors++; $display("FAIL addu_wd: got %h %h %0d want 3 1 1", wd, wreg, stall_cnt); end
    endtask

    task automatic test_immediates();
        clear_fwd();
        reg1_data = 32'h1111_1111; reg2_data = 32'h2222_2222;
        if_inst = 32'h3C03_ABCD; // lui $3,0xABCD
        tick();
        checks++; if ({reg1, reg2} !== {32'h0, 32'hABCD_0000}) begin errors++; $display("FAIL lui_ops: got %h %h want 0 ABCD0000", reg1, reg2); end
        checks++; if ({aluop, wd} !== {OP_OR, 5'd3}) begin errors++; $display("FAIL lui_op: got %h %h want %h 3", aluop, wd, OP_OR); end
        if_inst = 32'h3041_8000; // andi $1,$2,0x8000
        tick();
        checks++; if ({reg1, reg2} !== {32'h1111_1111, 32'h0000_8000}) begin errors++; $display("FAIL andi_ops: got %h %h want 11111111 00008000", reg1, reg2); end
        checks++; if ({aluop, alusel} !== {OP_AND, SEL_LOGIC}) begin errors++; $display("FAIL andi_op: got %h %h", aluop, alusel); end
        if_inst = 32'h8C22_FFFC; // lw $2,-4($1)
        tick();
        checks++; if ({reg1, reg2} !== {32'h1111_1111, 32'hFFFF_FFFC}) begin errors++; $display("FAIL lw_ops: got %h %h want 11111111 FFFFFFFC", reg1, reg2); end
        checks++; if ({aluop, alusel, is_load, wd, wreg} !== {OP_LW, SEL_LS, 1'b1, 5'd2, 1'b1}) begin errors++; $display("FAIL lw_ctrl: got %h %h %h %h %h", aluop, alusel, is_load, wd, wreg); end
    endtask

    task automatic test_shift();
        clear_fwd();
        reg2_data = 32'h1234_5678; if_inst = 32'h0001_2900;
        tick();
        checks++; if ({reg1, reg2} !== {32'h4, 32'h1234_5678}) begin errors++; $display("FAIL sll_ops: got %h %h want 00000004 12345678", reg1, reg2); end
        checks++; if ({aluop, alusel} !== {OP_SLL, SEL_SHIFT}) begin errors++; $display("FAIL sll_op: got %h %h want %h %h", aluop, alusel, OP_SLL, SEL_SHIFT); end
        checks++; if ({wd, wreg, is_load} !== {5'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL sll_wd: got %h %h %h want 5 1 0", wd, wreg, is_load); end
        if_inst = 32'h0000_0000;
        tick();
        checks++; if ({id_valid, wreg, reg1} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL nop_wreg: got %h %h %h want 1 0 0", id_valid, wreg, reg1); end
    endtask

    task automatic test_flush_stall();
        ex_ready = 1'b0; ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd2;
        if_inst = 32'h0042_1821;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %h want 0", id_ready); end
        tick();
        checks++; if ({id_valid, aluop, stall_cnt} !== {1'b1, OP_SLL, 4'd2}) begin errors++; $display("FAIL hold_regs: got %h %h %0d want 1 %h 2", id_valid, aluop, stall_cnt, OP_SLL); end
        flush = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %h want 1", id_ready); end
        tick();
        flush = 1'b0;
        checks++; if ({id_valid, wreg} !== 2'b00) begin errors++; $display("FAIL flush_valid: got %h %h want 0 0", id_valid, wreg); end
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL flush_cnt: got %0d want 2", stall_cnt); end
        clear_fwd();
        ex_ready = 1'b1; if_inst = 32'hFC00_0000;
        tick();
        checks++; if ({id_valid, invalid, wreg} !== 3'b110) begin errors++; $display("FAIL inval: got %h %h %h want 1 1 0", id_valid, invalid, wreg); end
        checks++; if ({aluop, alusel} !== {OP_NOP, SEL_NOP}) begin errors++; $display("FAIL inval_op: got %h %h want 0 0", aluop, alusel); end
    endtask

    task automatic test_reset_mid_stall();
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd2; if_inst = 32'h0042_1821;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL pre_rst_cnt: got %0d want 5", stall_cnt); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", stall_cnt); end
        checks++; if ({id_valid, aluop, pc, invalid, wreg} !== {1'b0, OP_NOP, 32'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_rst_regs: got %h %h %h %h %h", id_valid, aluop, pc, invalid, wreg); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 14; i++) tick();
        checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_count: got %0d want 14", stall_cnt); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_max: got %0d want 15", stall_cnt); end
        checks++; if (nf_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_nofwd: got %0d want 15", nf_stall_cnt); end
        clear_fwd();
    endtask

    initial begin
        test_reset();
        test_ori();
        test_forward();
        test_load_use();
        test_immediates();
        test_shift();
        test_flush_stall();
        test_reset_mid_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised instruction-decode stage for the 5-stage MIPS pipeline; sits between the IF/ID register and EX.
- Decodes the logic, shift, compare, add and load subset.
- Resolves operands with EX/MEM forwarding, detects load-use hazards and stalls upstream.
- Presents decoded fields to EX through an internal ID/EX register with valid/ready handshake, flush and a saturating stall counter.

Parameters:
DATA_W, 32, datapath/register width
REG_ADDR_W, 5, register-file address width
FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = regfile data only; load-use stalls still apply
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
if_valid_i  input  1  IF/ID holds a valid instruction
if_pc_i  input  32  instruction address
if_inst_i  input  32  instruction word
id_ready_o  output  1  ID accepts the instruction this cycle
reg1_read_o, reg2_read_o  output  1  regfile read enables (combinational)
reg1_addr_o, reg2_addr_o  output  REG_ADDR_W  regfile read addresses (combinational)
reg1_data_i, reg2_data_i  input  DATA_W  regfile read data
ex_wreg_i, mem_wreg_i  input  1  EX/MEM stage will write a register
ex_wd_i, mem_wd_i  input  REG_ADDR_W  EX/MEM destination register
ex_wdata_i, mem_wdata_i  input  DATA_W  EX/MEM result
ex_is_load_i  input  1  EX holds a load (data not yet available)
ex_ready_i  input  1  EX accepts the ID/EX register contents
flush_i  input  1  kill the ID/EX contents and the current decode
id_valid_o  output  1  ID/EX register valid
aluop_o  output  AluOp width  ALU operation
alusel_o  output  AluSel width  result-class select
reg1_o, reg2_o  output  DATA_W  resolved operands
wd_o  output  REG_ADDR_W  destination register
wreg_o  output  1  write enable
is_load_o  output  1  load instruction
pc_o  output  32  instruction address
inst_invalid_o  output  1  unsupported opcode decoded
stall_cnt_o  output  CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset (rst=0 at a clk edge): id_valid_o=0, aluop=NOP, alusel=RES_NOP, reg1_o/reg2_o/wd_o/pc_o=0, wreg_o/is_load_o/inst_invalid_o=0, stall_cnt_o=0. Reset dominates flush and stall; a stall in progress is abandoned.
- Decode is combinational from if_inst_i.
  - SPECIAL opcode: AND OR XOR NOR SLT SLTU ADDU SUBU SLLV SRLV SRAV SLL SRL SRA.
  - I-type: ANDI ORI XORI LUI SLTI SLTIU ADDIU LW.
  - Destination is rd for SPECIAL and rt for I-type.
- Immediates:
  - Logic immediates zero-extend; SLTI/SLTIU/ADDIU/LW sign-extend.
  - LUI: aluop OR, reg1 address forced to 0, imm = {inst[15:0],16'h0}.
  - SLL/SRL/SRA: reg1_o = shamt zero-extended to DATA_W; upper bits are 0, never stale.
- LW: aluop LW, alusel LOADSTORE, reg2_o = sign-extended offset, is_load=1.
- Unknown opcode/funct: NOP, wreg=0, inst_invalid=1.
- wreg_o is forced 0 whenever the destination is $0.
- Operand resolution, per port, when its read enable is set:
  - Address 0 → 0.
  - Else, if FWD_EN and ex_wreg_i and ex_wd_i == address → ex_wdata_i.
  - Else, if FWD_EN and mem_wreg_i and mem_wd_i == address → mem_wdata_i.
  - Else regfile data. EX has priority over MEM.
  - Port without read enable → immediate.
- Load-use hazard: if_valid_i & ex_is_load_i & ex_wreg_i & ex_wd_i≠0 & ex_wd_i matches an enabled nonzero read address.
  - Effect: id_ready_o=0.
  - If the ID/EX register is advancing, a bubble is loaded (id_valid_o=0).
  - stall_cnt_o increments once per hazard cycle and saturates at all-ones.
- Advance condition: ex_ready_i | ~id_valid_o.
  - id_ready_o = advance & ~hazard.
  - Not advancing: the ID/EX register holds all values.
  - Advancing: load the decoded instruction with id_valid_o=if_valid_i, or a bubble on hazard.
- flush_i: next edge id_valid_o=0 and wreg_o=0, irrespective of advance; id_ready_o=1 so IF can discard.
  - Flush beats hazard; stall_cnt_o does not increment during flush.
- One cycle of latency from acceptance to id_valid_o.

Decomposition:
- Shared defines package holds:
  - opcode/funct constants, including ADDU/SUBU/ADDIU/LW;
  - AluOp/AluSel codes, including ADD/SUB/LW ops and RES_ARITH/RES_LOADSTORE;
  - ZeroWord, NOPRegAddr, RstEnable (active-low).
- One sub-module, id_fwd_mux: per-operand forwarding/zero/immediate selector, instantiated twice.

Test Plan:
- ori $1,$0,0x1234 (0x34011234), no forwarding → next cycle id_valid_o=1, aluop OR, reg1_o=0, reg2_o=0x00001234, wd_o=1, wreg_o=1.
- or $4,$1,$0 (0x00202025) with EX writing $1=0xAAAA0000 and MEM writing $1=0x00005555 → reg1_o=0xAAAA0000; with FWD_EN=0 → reg1_o=reg1_data_i.
- lw $2,0($1) in EX (ex_is_load_i=1, ex_wd_i=2), decode addu $3,$2,$2 (0x00421821) → id_ready_o=0, id_valid_o=0 next cycle, stall_cnt_o=1. Drop ex_is_load_i → addu issues with the forwarded value.
- sll $5,$1,4 (0x00012900) → reg1_o=0x00000004, reg2_o=$1 value, alusel SHIFT. Then 0x00000000 → wreg_o=0.
- flush_i during a stall, with ex_ready_i=0 → id_valid_o=0 next edge, stall_cnt_o unchanged. Invalid word 0xFC000000 → inst_invalid_o=1, wreg_o=0.
- rst=0 for one edge mid-stall with the counter at 5 → all outputs reset, stall_cnt_o=0. Force 2^CNT_W+3 hazard cycles → stall_cnt_o saturates at all-ones.
